// File: rtl/fp_sigsched_pkg.sv
// rtl/fp_sigsched_pkg.sv - shared types and defaults for the shared sigmoid scheduler
package fp_sigsched_pkg;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_SIG_LAT = 3;
  localparam int DEF_RDEPTH  = 2;
  // Tag width covers the largest supported requester count (8).
  localparam int TAG_W       = 3;

  typedef logic [63:0]      fp64_t;
  typedef logic [TAG_W-1:0] sched_tag_t;

  typedef struct packed {
    logic       valid;
    sched_tag_t tag;
  } tag_stage_t;
endpackage

// File: rtl/fp_sigsched_rrarb.sv
// rtl/fp_sigsched_rrarb.sv - round-robin arbiter, one-hot grant, pointer moves past each winner
module fp_sigsched_rrarb
  import fp_sigsched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_elig,
  output logic [NREQ-1:0] o_grant,
  output sched_tag_t      o_gidx
);
  sched_tag_t r_ptr;
  logic       w_any;
  int         w_idx;

  always_comb begin
    o_grant = '0;
    o_gidx  = '0;
    w_any   = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (!w_any && i_elig[w_idx]) begin
        w_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_gidx         = sched_tag_t'(w_idx);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (o_gidx == sched_tag_t'(NREQ-1)) ? '0 : o_gidx + 1'b1;
    end
  end
endmodule

// File: rtl/fp_sigmoid_sched.sv
// rtl/fp_sigmoid_sched.sv - shares one pipelined sigmoid core among NREQ requesters with credit flow control
// Optional build macro FP_SIGSCHED_IDLE_CE_EN gates the core clock enable while idle.
module fp_sigmoid_sched
  import fp_sigsched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int SIG_LAT = DEF_SIG_LAT,
  parameter int RDEPTH  = DEF_RDEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*64-1:0] req_data,
  output logic [NREQ-1:0]    resp_valid,
  input  logic [NREQ-1:0]    resp_ready,
  output logic [NREQ*64-1:0] resp_data,
  output logic               sig_ce,
  output logic [63:0]        sig_a,
  input  logic [63:0]        sig_o,
  output logic               busy
);
  localparam int PW = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int CW = $clog2(RDEPTH + 1);

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_grant;
  logic [NREQ-1:0] w_push;
  logic [NREQ-1:0] w_pop;
  sched_tag_t      w_gidx;
  logic            w_tp_any;
  tag_stage_t      r_tp [SIG_LAT+1];
  fp64_t           r_sig_a;

  fp_sigsched_rrarb #(.NREQ(NREQ)) u_arb (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_elig  (w_elig),
    .o_grant (w_grant),
    .o_gidx  (w_gidx)
  );

  always_comb begin
    w_tp_any = 1'b0;
    for (int k = 0; k <= SIG_LAT; k++) w_tp_any = w_tp_any | r_tp[k].valid;
  end

`ifdef FP_SIGSCHED_IDLE_CE_EN
  assign sig_ce = (|w_grant) | w_tp_any;
`else
  assign sig_ce = 1'b1;
`endif

  assign req_ready = w_grant;
  assign sig_a     = r_sig_a;
  assign busy      = w_tp_any | (|resp_valid);

  // The tag pipe mirrors the core pipeline so the last stage names the owner of sig_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig_a <= '0;
      for (int k = 0; k <= SIG_LAT; k++) r_tp[k] <= '0;
    end else begin
      if (|w_grant) r_sig_a <= req_data[64*w_gidx +: 64];
      if (sig_ce) begin
        r_tp[0] <= {|w_grant, w_gidx};
        for (int k = 1; k <= SIG_LAT; k++) r_tp[k] <= r_tp[k-1];
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    fp64_t         r_mem [RDEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_credit;

    assign w_elig[gi]     = req_valid[gi] & (r_credit != '0) & ~rst;
    assign w_push[gi]     = sig_ce & r_tp[SIG_LAT].valid & (r_tp[SIG_LAT].tag == sched_tag_t'(gi));
    assign resp_valid[gi] = (r_cnt != '0);
    assign w_pop[gi]      = resp_valid[gi] & resp_ready[gi];
    assign resp_data[64*gi +: 64] = resp_valid[gi] ? r_mem[r_rp] : '0;

    always_ff @(posedge clk) begin
      if (w_push[gi]) r_mem[r_wp] <= sig_o;
    end

    // Credits guarantee a push never meets a full FIFO, so no overflow check is needed.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wp     <= '0;
        r_rp     <= '0;
        r_cnt    <= '0;
        r_credit <= CW'(RDEPTH);
      end else begin
        if (w_push[gi]) r_wp <= (r_wp == PW'(RDEPTH-1)) ? '0 : r_wp + 1'b1;
        if (w_pop[gi])  r_rp <= (r_rp == PW'(RDEPTH-1)) ? '0 : r_rp + 1'b1;
        case ({w_push[gi], w_pop[gi]})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
        case ({w_grant[gi], w_pop[gi]})
          2'b10:   r_credit <= r_credit - 1'b1;
          2'b01:   r_credit <= r_credit + 1'b1;
          default: r_credit <= r_credit;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fp_sigmoid_sched.sv
// tb/tb_fp_sigmoid_sched.sv - scoreboard bench for fp_sigmoid_sched with an identity stub core
module tb_fp_sigmoid_sched;
  localparam int NREQ    = 4;
  localparam int SIG_LAT = 3;
  localparam int RDEPTH  = 2;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*64-1:0] req_data;
  logic [NREQ-1:0]    resp_valid;
  logic [NREQ-1:0]    resp_ready;
  logic [NREQ*64-1:0] resp_data;
  logic               sig_ce;
  logic [63:0]        sig_a;
  logic [63:0]        sig_o;
  logic               busy;

  fp_sigmoid_sched #(.NREQ(NREQ), .SIG_LAT(SIG_LAT), .RDEPTH(RDEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .sig_ce     (sig_ce),
    .sig_a      (sig_a),
    .sig_o      (sig_o),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Identity core: SIG_LAT ce-qualified register stages.
  logic [63:0] core_p [SIG_LAT];
  initial for (int k = 0; k < SIG_LAT; k++) core_p[k] = '0;
  always @(posedge clk) begin
    if (sig_ce) begin
      core_p[0] <= sig_a;
      for (int k = 1; k < SIG_LAT; k++) core_p[k] <= core_p[k-1];
    end
  end
  assign sig_o = core_p[SIG_LAT-1];

  typedef struct {
    logic [63:0] d;
    int          rdy;
    int          acc;
  } ent_t;

  ent_t q [NREQ][$];
  int   m_ptr = 0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stimulus-side scoreboard: predicts the grant and queues the expected response.
  always @(negedge clk) begin
    logic [NREQ-1:0] eg;
    int gi;
    int idx;
    eg = '0;
    gi = -1;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (gi < 0 && req_valid[idx] && q[idx].size() < RDEPTH) gi = idx;
      end
    end
    if (gi >= 0) eg[gi] = 1'b1;
    chk("grant", 64'(req_ready), 64'(eg));
    if (gi >= 0) begin
      q[gi].push_back('{d: req_data[64*gi +: 64], rdy: cyc + SIG_LAT + 2, acc: cyc});
      m_ptr = (gi + 1) % NREQ;
    end
  end

  // Response monitor: pops the scoreboard whenever a result is handed over.
  always @(negedge clk) begin
    logic eb;
    logic ev;
    #1;
    eb = 1'b0;
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < q[i].size(); j++)
        if (q[i][j].acc < cyc) eb = 1'b1;
    chk("busy", 64'(busy), 64'(eb));
    for (int i = 0; i < NREQ; i++) begin
      ev = (q[i].size() > 0) && (q[i][0].rdy <= cyc);
      chk($sformatf("resp_valid[%0d]", i), 64'(resp_valid[i]), 64'(ev));
      if (ev && resp_ready[i]) begin
        chk($sformatf("resp_data[%0d]", i), resp_data[64*i +: 64], q[i][0].d);
        void'(q[i].pop_front());
      end
    end
  end

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) req_data[64*i +: 64] = {$urandom, $urandom};
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic exp_idle_ce;
  int   lat;
  int   nacc;
  int   left;

  initial begin
`ifdef FP_SIGSCHED_IDLE_CE_EN
    exp_idle_ce = 1'b0;
`else
    exp_idle_ce = 1'b1;
`endif
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = '1;
    req_data   = '0;
    #12;
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    chk("reset resp_data_lo", resp_data[63:0], 64'd0);
    chk("reset resp_data_hi", resp_data[255:192], 64'd0);
    chk("reset sig_a", sig_a, 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset sig_ce", 64'(sig_ce), 64'(exp_idle_ce));
    @(posedge clk); #2;
    rst = 1'b0;

    // Single request latency and data.
    step(2);
    req_valid = 4'b0001;
    req_data[63:0] = 64'h4000000000000000;
    step(1);
    req_valid = '0;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid[0]) begin
        lat = k;
        break;
      end
    end
    chk("single latency", 64'(lat), 64'(SIG_LAT + 1));
    chk("single data", resp_data[63:0], 64'h4000000000000000);
    step(4);

    // Requester 1 blocked by credits, then released by a single pop.
    resp_ready = '0;
    req_valid  = 4'b0010;
    rand_data();
    nacc = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (req_valid[1] && req_ready[1]) nacc++;
    end
    chk("credit block accepts", 64'(nacc), 64'd2);
    step(1);
    resp_ready[1] = 1'b1;
    step(1);
    resp_ready[1] = 1'b0;
    nacc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_valid[1] && req_ready[1]) nacc++;
    end
    chk("one pop one accept", 64'(nacc), 64'd1);
    step(1);
    req_valid  = '0;
    resp_ready = '1;
    step(12);

    // All requesters valid continuously: strict rotation.
    req_valid = '1;
    for (int k = 0; k < 40; k++) begin
      rand_data();
      step(1);
    end
    req_valid = '0;
    step(12);

    // Requester 2 at credit 0 with full FIFO, then sustained pop+accept.
    resp_ready = '0;
    req_valid  = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      rand_data();
      step(1);
    end
    resp_ready[2] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      rand_data();
      step(1);
    end
    req_valid  = '0;
    resp_ready = '1;
    step(12);

    // Randomized traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      req_valid  = NREQ'($urandom);
      resp_ready = NREQ'($urandom);
      rand_data();
      step(1);
    end
    req_valid  = '0;
    resp_ready = '1;
    step(15);

    // Reset with ops in flight: nothing stale may surface afterwards.
    req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      rand_data();
      step(1);
    end
    req_valid = '0;
    #1;
    rst = 1'b1;
    #1;
    chk("midreset resp_valid", 64'(resp_valid), 64'd0);
    chk("midreset busy", 64'(busy), 64'd0);
    for (int i = 0; i < NREQ; i++) q[i].delete();
    m_ptr = 0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    step(10);
    chk("post reset idle valid", 64'(resp_valid), 64'd0);
    resp_ready = '0;
    req_valid  = 4'b0010;
    rand_data();
    nacc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_valid[1] && req_ready[1]) nacc++;
    end
    chk("credits restored", 64'(nacc), 64'd2);
    step(1);
    req_valid  = '0;
    resp_ready = '1;
    step(15);

    left = 0;
    for (int i = 0; i < NREQ; i++) left += q[i].size();
    chk("drain", 64'(left), 64'd0);
    chk("idle sig_ce", 64'(sig_ce), 64'(exp_idle_ce));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
